regfile_wb_arbiter: RTL and testbench

- Writer-side front end for the register-file write port (we/waddr/wdata).
- Merges two result producers into the single write port:
  - ALU/MEM-stage results, with a ready/valid handshake.
  - Late load returns from the memory controller, always accepted and highest priority.
- ALU results that lose arbitration wait in a small in-order queue.
- Exposes pending-write lookups so decode can stall on a register whose write is still queued.

---
 rtl/regfile_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU results and late load returns onto the register-file write port.
// Optional feature macro WB_ALU_BYPASS_EN: an accepted ALU result skips an empty queue and writes 1 cycle later.
module regfile_wb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_W-1:0]          alu_waddr,
    input  logic [DATA_W-1:0]          alu_wdata,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_waddr,
    input  logic [DATA_W-1:0]          ld_wdata,
    output logic                       we,
    output logic [ADDR_W-1:0]          waddr,
    output logic [DATA_W-1:0]          wdata,
    input  logic [ADDR_W-1:0]          chk_addr1,
    input  logic [ADDR_W-1:0]          chk_addr2,
    output logic                       pending1,
    output logic                       pending2,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]  q_valid;
    logic [DEPTH-1:0]  q_live;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic              ld_win;
    logic              acc;
    logic              empty;
    logic              pop;
    logic              push;
    logic              bypass;

    assign alu_ready = (count != CW'(DEPTH));
    assign empty     = (count == '0);
    assign ld_win    = ld_valid && (ld_waddr != '0);
    assign acc       = alu_valid && alu_ready && (alu_waddr != '0);
    assign pop       = !ld_win && !empty;
`ifdef WB_ALU_BYPASS_EN
    assign bypass    = acc && empty && !ld_win;
`else
    assign bypass    = 1'b0;
`endif
    assign push      = acc && !bypass;

    // Output stage, queue bookkeeping and load-driven kills; a same-cycle push is younger so its live bit wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we      <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_valid <= '0;
            q_live  <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (ld_win) begin
                we    <= 1'b1;
                waddr <= ld_waddr;
                wdata <= ld_wdata;
            end else if (pop) begin
                we <= q_live[rd_ptr];
                if (q_live[rd_ptr]) begin
                    waddr <= q_addr[rd_ptr];
                    wdata <= q_data[rd_ptr];
                end
            end else if (bypass) begin
                we    <= 1'b1;
                waddr <= alu_waddr;
                wdata <= alu_wdata;
            end else begin
                we <= 1'b0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (ld_win && q_valid[i] && (q_addr[i] == ld_waddr)) begin
                    q_live[i] <= 1'b0;
                end
            end
            if (pop) begin
                q_valid[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PW'(1);
            end
            if (push) begin
                q_valid[wr_ptr] <= 1'b1;
                q_live[wr_ptr]  <= 1'b1;
                wr_ptr          <= wr_ptr + PW'(1);
            end
        end
    end

    // Queue payload needs no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= alu_waddr;
            q_data[wr_ptr] <= alu_wdata;
        end
    end

    // Pending lookup over valid, live queue entries; x0 never reports pending.
    always_comb begin
        pending1 = 1'b0;
        pending2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && q_live[i]) begin
                pending1 = pending1 | (q_addr[i] == chk_addr1);
                pending2 = pending2 | (q_addr[i] == chk_addr2);
            end
        end
        if (chk_addr1 == '0) pending1 = 1'b0;
        if (chk_addr2 == '0) pending2 = 1'b0;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for regfile_wb_arbiter (DEPTH=2).
module tb_regfile_wb_arbiter;
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        ld_valid;
    logic [4:0]  ld_waddr;
    logic [31:0] ld_wdata;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        pending1;
    logic        pending2;
    logic [1:0]  count;

    wr_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;

    regfile_wb_arbiter #(.DEPTH(2), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .ld_valid(ld_valid), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
        .we(we), .waddr(waddr), .wdata(wdata),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .pending1(pending1), .pending2(pending2), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    // Every write on the port must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && we) begin
            if (sb.size() == 0) begin
                chk("unexpected_we", {27'd0, waddr, wdata}, 64'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 64'(waddr), 64'(e.a));
                chk("wr_data", 64'(wdata), 64'(e.d));
            end
        end
    end

    initial begin
        int k;
        int third_cyc;
        logic [4:0]  bp_a [3];
        logic [31:0] bp_d [3];
        rst = 1'b0;
        alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
        ld_valid = 1'b0; ld_waddr = '0; ld_wdata = '0;
        chk_addr1 = '0; chk_addr2 = '0;
        step();
        step();
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_waddr", 64'(waddr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        rst = 1'b1;
        step();

        // Single ALU result with idle queue
        sb.push_back('{5'd5, 32'h11});
        alu_valid = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'h11; chk_addr1 = 5'd5;
        step();
        idle();
`ifdef WB_ALU_BYPASS_EN
        chk("alu_bypass_we", 64'(we), 64'd1);
        chk("alu_bypass_pend", 64'(pending1), 64'd0);
`else
        chk("alu_mid_we", 64'(we), 64'd0);
        chk("alu_mid_pend", 64'(pending1), 64'd1);
        chk("alu_mid_count", 64'(count), 64'd1);
        step();
        chk("alu_we", 64'(we), 64'd1);
`endif
        chk("alu_pend_clear", 64'(pending1), 64'd0);
        step();
        step();
        chk("alu_sb_empty", 64'(sb.size()), 64'd0);

        // Load and ALU collide in one cycle
        sb.push_back('{5'd3, 32'hAA});
        sb.push_back('{5'd4, 32'hBB});
        ld_valid = 1'b1; ld_waddr = 5'd3; ld_wdata = 32'hAA;
        alu_valid = 1'b1; alu_waddr = 5'd4; alu_wdata = 32'hBB;
        step();
        idle();
        chk("col_count1", 64'(count), 64'd1);
        chk("col_waddr1", 64'(waddr), 64'd3);
        step();
        chk("col_count0", 64'(count), 64'd0);
        chk("col_waddr2", 64'(waddr), 64'd4);
        step();
        chk("col_sb_empty", 64'(sb.size()), 64'd0);

        // Load kills an older queued write to the same register
        sb.push_back('{5'd1, 32'h50});
        sb.push_back('{5'd1, 32'h51});
        sb.push_back('{5'd7, 32'h99});
        sb.push_back('{5'd8, 32'h2});
        chk_addr1 = 5'd7; chk_addr2 = 5'd8;
        ld_valid = 1'b1; ld_waddr = 5'd1; ld_wdata = 32'h50;
        alu_valid = 1'b1; alu_waddr = 5'd7; alu_wdata = 32'h1;
        step();
        ld_wdata = 32'h51;
        alu_waddr = 5'd8; alu_wdata = 32'h2;
        step();
        chk("kill_pend_before", 64'(pending1), 64'd1);
        alu_valid = 1'b0;
        ld_waddr = 5'd7; ld_wdata = 32'h99;
        step();
        idle();
        chk("kill_count", 64'(count), 64'd2);
        chk("kill_pend7", 64'(pending1), 64'd0);
        chk("kill_pend8", 64'(pending2), 64'd1);
        step();
        chk("kill_pop_we", 64'(we), 64'd0);
        chk("kill_pop_count", 64'(count), 64'd1);
        step();
        chk("kill_x8_we", 64'(we), 64'd1);
        chk("kill_count0", 64'(count), 64'd0);
        step();
        chk("kill_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure under a 4-cycle load stream
        bp_a[0] = 5'd10; bp_a[1] = 5'd11; bp_a[2] = 5'd12;
        bp_d[0] = 32'hA0; bp_d[1] = 32'hA1; bp_d[2] = 32'hA2;
        for (int i = 0; i < 4; i++) sb.push_back('{5'd1, 32'h60 + 32'(i)});
        for (int i = 0; i < 3; i++) sb.push_back('{bp_a[i], bp_d[i]});
        k = 0;
        third_cyc = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            logic acc;
            ld_valid = (cyc < 4); ld_waddr = 5'd1; ld_wdata = 32'h60 + 32'(cyc);
            alu_valid = (k < 3);
            if (k < 3) begin
                alu_waddr = bp_a[k];
                alu_wdata = bp_d[k];
            end
            if (cyc == 2) begin
                chk("bp_ready_full", 64'(alu_ready), 64'd0);
                chk("bp_count_full", 64'(count), 64'd2);
            end
            acc = alu_valid && alu_ready;
            if (acc && k == 2) third_cyc = cyc;
            step();
            if (acc) k++;
            if (k == 3 && cyc >= 3) break;
        end
        idle();
        chk("bp_third_cyc", 64'(third_cyc), 64'd5);
        repeat (4) step();
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Writes to x0 are ignored
        chk_addr1 = 5'd0;
        alu_valid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'hDEAD;
        ld_valid = 1'b1; ld_waddr = 5'd0; ld_wdata = 32'hBEEF;
        step();
        chk("x0_count", 64'(count), 64'd0);
        chk("x0_we", 64'(we), 64'd0);
        chk("x0_pend", 64'(pending1), 64'd0);
        chk("x0_ready", 64'(alu_ready), 64'd1);
        step();
        idle();
        chk("x0_we2", 64'(we), 64'd0);

        // Reset with two queued entries discards them
        sb.push_back('{5'd1, 32'h70});
        sb.push_back('{5'd1, 32'h71});
        chk_addr1 = 5'd13;
        ld_valid = 1'b1; ld_waddr = 5'd1; ld_wdata = 32'h70;
        alu_valid = 1'b1; alu_waddr = 5'd13; alu_wdata = 32'hC0;
        step();
        ld_wdata = 32'h71;
        alu_waddr = 5'd14; alu_wdata = 32'hC1;
        step();
        idle();
        chk("prerst_count", 64'(count), 64'd2);
        chk("prerst_pend", 64'(pending1), 64'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("arst_we", 64'(we), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_pend", 64'(pending1), 64'd0);
        chk("arst_waddr", 64'(waddr), 64'd0);
        step();
        rst = 1'b1;
        repeat (6) step();
        chk("postrst_count", 64'(count), 64'd0);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
